// File: rtl/imem_ctrl.sv
// Instruction-memory controller: boot-load write stream, then loader/fetch arbitration
// with a fixed-latency read adapted to a valid/ready fetch response.
module imem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_add,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [ADDR_W-1:0] f_add,
    output logic              f_rsp_valid,
    output logic [DATA_W-1:0] f_rsp_data,
    input  logic              f_rsp_ready,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              booted,
    output logic [ADDR_W:0]   wr_count
);

    typedef enum logic [1:0] {BOOT, IDLE, RD_WAIT, RSP} state_t;

    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [1:0]      LAT_INIT = 2'(RD_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_add;
    logic [1:0]        r_lat;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_booted;
    logic [ADDR_W:0]   r_wr_count;
    logic              w_ld_acc;
    logic              w_rd_acc;

    // Loader wins over fetch in IDLE; reads only start from IDLE.
    assign w_ld_acc = ld_valid && (r_state != RD_WAIT);
    assign w_rd_acc = (r_state == IDLE) && !ld_valid && f_req_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            BOOT: begin
                if (w_ld_acc && (ld_last || (r_wr_count >= DEPTH_C - 1'b1)))
                    w_next = IDLE;
            end
            IDLE: begin
                if (w_rd_acc)
                    w_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (r_lat == 2'd0)
                    w_next = RSP;
            end
            RSP: begin
                if (f_rsp_ready)
                    w_next = IDLE;
            end
            default: w_next = BOOT;
        endcase
    end

    always_comb begin
        ld_ready    = w_ld_acc;
        f_req_ready = w_rd_acc;
        mem_w_en    = w_ld_acc;
        mem_r_en    = w_rd_acc;
        mem_data_in = '0;
        mem_add     = '0;
        f_rsp_valid = (r_state == RSP);
        if (w_ld_acc) begin
            mem_add     = ld_add;
            mem_data_in = ld_data;
        end else if (w_rd_acc) begin
            mem_add = f_add;
        end else if (r_state == RD_WAIT) begin
            mem_add = r_add;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_add      <= '0;
            r_lat      <= '0;
            r_rsp_data <= '0;
            r_booted   <= 1'b0;
            r_wr_count <= '0;
        end else begin
            if (w_ld_acc && (r_wr_count < DEPTH_C))
                r_wr_count <= r_wr_count + 1'b1;
            if ((r_state == BOOT) && (w_next == IDLE))
                r_booted <= 1'b1;
            if (w_rd_acc) begin
                r_add <= f_add;
                r_lat <= LAT_INIT;
            end else if (r_state == RD_WAIT) begin
                if (r_lat == 2'd0)
                    r_rsp_data <= mem_data_out;
                else
                    r_lat <= r_lat - 1'b1;
            end
        end
    end

    assign f_rsp_data = r_rsp_data;
    assign booted     = r_booted;
    assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a behavioural imem and a response scoreboard.
module tb_imem_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_valid, ld_ready, ld_last;
    logic [ADDR_W-1:0] ld_add;
    logic [DATA_W-1:0] ld_data;
    logic              f_req_valid, f_req_ready;
    logic [ADDR_W-1:0] f_add;
    logic              f_rsp_valid, f_rsp_ready;
    logic [DATA_W-1:0] f_rsp_data;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_data_in, mem_data_out;
    logic              mem_r_en, mem_w_en, booted;
    logic [ADDR_W:0]   wr_count;

    logic [DATA_W-1:0] mem_model [DEPTH];
    logic [DATA_W-1:0] ref_mem   [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    int                n_chk  = 0;
    int                n_fail = 0;
    int                exp_wr = 0;
    logic              exp_booted = 1'b0;

    always #5 clk = ~clk;

    imem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_add(ld_add), .ld_data(ld_data), .ld_last(ld_last),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_add(f_add),
        .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_ready(f_rsp_ready),
        .mem_add(mem_add), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .booted(booted), .wr_count(wr_count)
    );

    // Single-port imem, one-cycle registered read.
    always @(posedge clk) begin
        if (mem_w_en) mem_model[mem_add] <= mem_data_in;
        if (mem_r_en) mem_data_out <= mem_model[mem_add];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic last);
        int t;
        ld_valid = 1'b1; ld_add = a; ld_data = d; ld_last = last;
        #1;
        t = 0;
        while (!ld_ready && t < 20) begin step(); t++; end
        chk("ld_ready", 64'(ld_ready), 64'(1));
        chk("wr_w_en", 64'(mem_w_en), 64'(1));
        chk("wr_add", 64'(mem_add), 64'(a));
        chk("wr_data", 64'(mem_data_in), 64'(d));
        chk("wr_no_r_en", 64'(mem_r_en), 64'(0));
        chk("wr_blocks_fetch", 64'(f_req_ready), 64'(0));
        if (ld_ready) begin
            ref_mem[a] = d;
            if (exp_wr < DEPTH) exp_wr++;
            if (!exp_booted && (last || exp_wr == DEPTH)) exp_booted = 1'b1;
        end
        step();
        ld_valid = 1'b0; ld_last = 1'b0; ld_add = '0; ld_data = '0;
        #1;
        chk("wr_count", 64'(wr_count), 64'(exp_wr));
        chk("booted", 64'(booted), 64'(exp_booted));
    endtask

    // Leaves f_req_valid high after the accept edge so RD_WAIT can be probed.
    task automatic fetch_accept(input logic [ADDR_W-1:0] a, output int waits);
        f_req_valid = 1'b1; f_add = a;
        #1;
        waits = 0;
        while (!f_req_ready && waits < 300) begin step(); waits++; end
        chk("req_accept", 64'(f_req_ready), 64'(1));
        chk("rd_r_en", 64'(mem_r_en), 64'(1));
        chk("rd_add", 64'(mem_add), 64'(a));
        chk("rd_no_w_en", 64'(mem_w_en), 64'(0));
        if (f_req_ready) exp_q.push_back(ref_mem[a]);
        step();
    endtask

    task automatic fetch_wait(input logic [ADDR_W-1:0] a);
        int n;
        n = 1;
        while (!f_rsp_valid && n < 10) begin
            chk("rdwait_no_req", 64'(f_req_ready), 64'(0));
            chk("rdwait_r_en", 64'(mem_r_en), 64'(0));
            chk("rdwait_add", 64'(mem_add), 64'(a));
            step();
            n++;
        end
        f_req_valid = 1'b0; f_add = '0;
        #1;
        chk("rsp_latency", 64'(n), 64'(RD_LAT + 1));
        chk("rsp_valid", 64'(f_rsp_valid), 64'(1));
    endtask

    task automatic fetch_consume();
        logic [DATA_W-1:0] e;
        f_rsp_ready = 1'b1;
        #1;
        chk("consume_valid", 64'(f_rsp_valid), 64'(1));
        chk("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_data", 64'(f_rsp_data), 64'(e));
        end
        step();
        f_rsp_ready = 1'b0;
        #1;
        chk("rsp_done", 64'(f_rsp_valid), 64'(0));
    endtask

    task automatic reset_checks();
        chk("rst_rsp_valid", 64'(f_rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(f_rsp_data), 64'(0));
        chk("rst_booted", 64'(booted), 64'(0));
        chk("rst_wr_count", 64'(wr_count), 64'(0));
        chk("rst_r_en", 64'(mem_r_en), 64'(0));
        chk("rst_fetch_blocked", 64'(f_req_ready), 64'(0));
        exp_q.delete();
        exp_wr = 0;
        exp_booted = 1'b0;
    endtask

    initial begin
        int w;
        for (int i = 0; i < DEPTH; i++) begin mem_model[i] = '0; ref_mem[i] = '0; end
        rst = 1'b1; ld_valid = 1'b0; ld_add = '0; ld_data = '0; ld_last = 1'b0;
        f_req_valid = 1'b0; f_add = '0; f_rsp_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("init_w_en", 64'(mem_w_en), 64'(0));
        chk("init_add", 64'(mem_add), 64'(0));
        chk("init_data_in", 64'(mem_data_in), 64'(0));
        reset_checks();

        // Boot with a fetch already pending on address 3.
        f_req_valid = 1'b1; f_add = 8'd3;
        for (int i = 0; i < 8; i++) do_write(8'(i), 32'(i), i == 7);
        fetch_accept(8'd3, w);
        chk("boot_fetch_wait", 64'(w), 64'(0));
        fetch_wait(8'd3);
        fetch_consume();

        // Simultaneous write and fetch in IDLE: write first, read next cycle.
        f_req_valid = 1'b1; f_add = 8'd5;
        do_write(8'd5, 32'hDEADBEEF, 1'b0);
        fetch_accept(8'd5, w);
        chk("rd_next_cycle", 64'(w), 64'(0));
        fetch_wait(8'd5);
        fetch_consume();

        // Response held while the loader overwrites the same address.
        fetch_accept(8'd2, w);
        fetch_wait(8'd2);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) do_write(8'd2, 32'h12345678, 1'b0);
            else step();
            chk("hold_valid", 64'(f_rsp_valid), 64'(1));
            chk("hold_data", 64'(f_rsp_data), 64'(32'h00000002));
        end
        fetch_consume();
        fetch_accept(8'd2, w);
        fetch_wait(8'd2);
        fetch_consume();

        // Reset during RD_WAIT.
        fetch_accept(8'd1, w);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        reset_checks();

        // Reboot, then reset during RSP.
        f_req_valid = 1'b1; f_add = 8'd7;
        do_write(8'd7, 32'h00000007, 1'b1);
        fetch_accept(8'd7, w);
        fetch_wait(8'd7);
        rst = 1'b1; f_req_valid = 1'b1;
        step();
        rst = 1'b0;
        #1;
        reset_checks();
        f_req_valid = 1'b0;

        // Full-depth boot without ld_last, then saturation.
        for (int i = 0; i < DEPTH; i++) do_write(8'(i), 32'hA5A50000 | 32'(i), 1'b0);
        chk("full_boot_count", 64'(wr_count), 64'(DEPTH));
        do_write(8'h10, 32'h0BADF00D, 1'b1);
        chk("saturated", 64'(wr_count), 64'(DEPTH));
        fetch_accept(8'h10, w);
        fetch_wait(8'h10);
        fetch_consume();
        fetch_accept(8'd200, w);
        fetch_wait(8'd200);
        fetch_consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
